// File: rtl/dac_pkg.sv
// dac_pkg: shared DAC-path constants and the FSM state type reused by the DAC drivers
package dac_pkg;
  localparam int unsigned FS_MV_DEFAULT = 3300;
  localparam int unsigned CODE_MAX = 255;
  localparam int NUM_W = 24;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/mv_to_code8.sv
// mv_to_code8: rounds a millivolt setpoint to an 8-bit DAC code with a bit-serial restoring divider
module mv_to_code8
  import dac_pkg::*;
#(
  parameter int unsigned FS_MV = FS_MV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mV_in,
  output logic        busy,
  output logic        done,
  output logic [7:0]  code_out,
  output logic        sat_out
);
  localparam logic [15:0] FS = 16'(FS_MV);
  state_t state, state_next;
  logic [NUM_W-1:0] rem;
  logic [7:0] q;
  logic [2:0] idx;
  logic sat;
  logic [15:0] clamped;
  logic [NUM_W-1:0] num;
  logic [NUM_W:0] trial;
  logic accept, fits;
  assign clamped = (mV_in > FS) ? FS : mV_in;
  assign num = ({8'd0, clamped} << 8) - {8'd0, clamped} + NUM_W'(FS >> 1);
  assign trial = {1'b0, rem} - ({9'd0, FS} << idx);
  assign fits = !trial[NUM_W];
  assign accept = start && (state == IDLE || state == DONE);
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // next state; busy/done decode straight from the state register
  always_comb begin
    state_next = accept ? DIV : (state == DIV) ? ((idx == 3'd0) ? DONE : DIV) : IDLE;
    busy = state == DIV;
    done = state == DONE;
  end
  // divider datapath: one quotient bit per DIV cycle, outputs land as DONE is entered
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      q <= '0;
      idx <= '0;
      sat <= 1'b0;
      code_out <= '0;
      sat_out <= 1'b0;
    end else if (accept) begin
      rem <= num;
      q <= '0;
      idx <= 3'd7;
      sat <= mV_in > FS;
    end else if (state == DIV) begin
      if (fits) rem <= trial[NUM_W-1:0];
      q[idx] <= fits;
      idx <= idx - 3'd1;
      if (idx == 3'd0) begin
        code_out <= {q[7:1], fits};
        sat_out <= sat;
      end
    end
  end
endmodule

// File: tb/tb_mv_to_code8.sv
// tb_mv_to_code8: directed and random checks of mv_to_code8 against a rounding reference
module tb_mv_to_code8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [15:0] mV_in = '0;
  logic busy, done, sat_out;
  logic [7:0] code_out;
  int checks = 0;
  int failures = 0;

  mv_to_code8 dut (
    .clk(clk), .reset(reset), .start(start), .mV_in(mV_in),
    .busy(busy), .done(done), .code_out(code_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  function automatic int ref_code(input int x);
    int m;
    m = (x > 3300) ? 3300 : x;
    return (m * 255 + 1650) / 3300;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int k0, input int exp_code, input int exp_sat);
    int k;
    k = k0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".lat"}, k, 9);
    check({tag, ".code"}, int'(code_out), exp_code);
    check({tag, ".sat"}, int'(sat_out), exp_sat);
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input int exp_code, input int exp_sat);
    @(negedge clk);
    start = 1'b1;
    mV_in = v;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy"}, int'(busy), 1);
    wait_done(tag, 1, exp_code, exp_sat);
    @(negedge clk);
    check({tag, ".pulse"}, int'(done), 0);
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  initial begin
    int k;
    logic [15:0] v;
    repeat (2) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.code", int'(code_out), 0);
    check("rst.sat", int'(sat_out), 0);
    reset = 1'b0;

    convert("zero", 16'd0, 0, 0);
    convert("full", 16'd3300, 255, 0);
    convert("over", 16'd5000, 255, 1);
    convert("half", 16'd1650, 128, 0);
    convert("mv1000", 16'd1000, 77, 0);
    check("roundtrip", (int'(code_out) * 3313) >> 8, 996);
    convert("mv13", 16'd13, 1, 0);
    convert("mv6", 16'd6, 0, 0);
    convert("mv7", 16'd7, 1, 0);
    convert("max", 16'hFFFF, 255, 1);

    @(negedge clk);
    start = 1'b1;
    mV_in = 16'd1000;
    @(negedge clk);
    mV_in = 16'd2000;
    wait_done("b2b1", 1, 77, 0);
    @(negedge clk);
    start = 1'b0;
    check("b2b2.busy", int'(busy), 1);
    check("b2b2.hold", int'(code_out), 77);
    wait_done("b2b2", 1, 155, 0);
    count_dones("b2b.extra", 12);

    @(negedge clk);
    start = 1'b1;
    mV_in = 16'd1650;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    repeat (2) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    mV_in = 16'd5000;
    @(negedge clk);
    k++;
    start = 1'b0;
    check("ign.hold", int'(code_out), 155);
    wait_done("ign", k, 128, 0);
    count_dones("ign.extra", 15);

    @(negedge clk);
    start = 1'b1;
    mV_in = 16'd5000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.code", int'(code_out), 0);
    check("abort.sat", int'(sat_out), 0);
    reset = 1'b0;
    count_dones("abort.nodone", 12);
    convert("post", 16'd1000, 77, 0);

    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom_range(0, 65535));
      if (i % 4 == 0) v = v % 16'd3400;
      convert($sformatf("rnd%0d_%0d", i, v), v, ref_code(int'(v)), (v > 16'd3300) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mv_to_code8.md
# mV_to_code8

Converts a requested millivolt setpoint (0–3300 mV) into the nearest 8-bit DAC code (0–255) for the discrete R-2R / PWM DAC paths. It is the inverse of the code-to-millivolt scaling on the ADC side. It uses a start/done handshake and a bit-serial restoring divider, so no multiplier or divider primitives are needed. It sits between the setpoint source (switches / UART command decoder) and the DAC drivers.

## Interface
- FS_MV, 3300, full-scale millivolts mapping to code 255; legal range 1..65535.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- start  input  1  request strobe; sampled only while busy=0.
- mV_in  input  16  requested setpoint in mV, unsigned.
- busy  output  1  conversion in progress; start ignored while high.
- done  output  1  one-cycle strobe; code_out/sat_out updated this cycle.
- code_out  output  8  rounded DAC code; holds until next done.
- sat_out  output  1  1 if last accepted mV_in exceeded FS_MV; updates with code_out.

## Operation
- Function: code = floor((min(mV_in, FS_MV)·255 + FS_MV/2) / FS_MV), with integer FS_MV/2 = FS_MV>>1.
- ·255 is formed as (x<<8) − x in a 24-bit numerator. The maximum numerator is FS_MV·255 + FS_MV/2, which is below FS_MV·256, so the quotient always fits in 8 bits.
- FSM states:
  - IDLE: busy=0. If start=1, clamp mV_in, latch sat, load the numerator into the 24-bit remainder, set bit index to 7, go to DIV.
  - DIV: busy=1. Compute trial = rem − (FS_MV << idx). If trial ≥ 0, set rem=trial and q[idx]=1; otherwise q[idx]=0. If idx==0, go to DONE; otherwise decrement idx.
  - DONE: busy=0, done=1. Register code_out=q and sat_out=latched sat. Next state is IDLE, or DIV directly if start=1 this cycle (back-to-back accept).
- start while busy=1: ignored, not queued. mV_in is only sampled in the accepting cycle.
- Reset values: busy=0, done=0, code_out=0, sat_out=0, FSM=IDLE, internal remainder/quotient cleared.
- Reset mid-conversion aborts immediately. No done is issued and outputs return to reset values.

## Timing
- start sampled high at cycle N (IDLE) → busy=1 in cycles N+1..N+8 → done=1 with the new code_out in cycle N+9.
- Latency is fixed at 9 cycles, independent of value. Throughput is one conversion per 9 cycles with back-to-back starts.
- done is high for exactly 1 cycle per accepted start.
- code_out and sat_out change only in the done cycle or on reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package dac_pkg holds:
  - FS_MV_DEFAULT = 3300 and CODE_MAX = 255;
  - NUM_W = 24;
  - the FSM enum typedef {IDLE, DIV, DONE}, which the PWM DAC driver FSM reuses.
- Single module with no sub-module. The divider step is a few lines and stays inline.

## Test plan
- Reset, then start with mV_in=0 → done at N+9, code_out=0, sat_out=0.
- mV_in=3300 → code_out=255, sat_out=0. mV_in=5000 → code_out=255, sat_out=1.
- mV_in=1650 → code_out=128. mV_in=1000 → code_out=77. mV_in=13 → code_out=1 (rounding boundary). Round-trip check: 77·3313>>8 = 996 mV.
- Back-to-back starts with start held high across the done cycle, values 1000 then 2000:
  - done at N+9 with 77 and at N+18 with 155;
  - a start pulse issued during busy is ignored.
- Assert reset at N+4 mid-conversion → no done, outputs return to 0 next cycle; a fresh start after reset completes normally.
- Random mV_in 0..65535 against the reference model floor((min(x,3300)·255+1650)/3300): exact match, and exactly one done per accepted start.
